// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: default geometry
// and the state encoding of the input skew buffer.
package systolic_pkg;

    localparam int LANES_DEFAULT  = 8;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } skew_state_t;

endpackage

// File: rtl/lane_delay.sv
// One lane of the skew buffer: DEPTH enable-gated delay stages followed by
// an output register; 'direct' loads the output straight from the input.
module lane_delay #(
    parameter int DEPTH  = 0,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              shift_en,
    input  logic              direct,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] tap;

    generate
        if (DEPTH == 0) begin : g_no_delay
            assign tap = d;
        end else begin : g_delay
            logic [DATA_W-1:0] stages [DEPTH];

            // The chain is left untouched by direct loads so that a later
            // skewed tile never sees rows that were meant to bypass it.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stages[k] <= '0;
                    end
                end else if (shift_en && !direct) begin
                    stages[0] <= d;
                    for (int k = 1; k < DEPTH; k++) begin
                        stages[k] <= stages[k-1];
                    end
                end
            end

            assign tap = stages[DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= direct ? d : tap;
        end
    end

endmodule

// File: rtl/input_skew_buffer.sv
// Diagonal-wavefront skew buffer feeding a systolic array; lane i is delayed
// by i advances. Optional macro SKEW_BYPASS_EN adds an unskewed bypass mode.
module input_skew_buffer
    import systolic_pkg::*;
#(
    parameter int LANES  = LANES_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    n_rst,
`ifdef SKEW_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    input  logic                    stall,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_enable,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam skew_state_t LAST_ROW_STATE = (LANES > 1) ? DRAIN : DONE;

    skew_state_t            state;
    logic [CNT_W-1:0]       drain_cnt;
    logic                   accept;
    logic                   drain_step;
    logic                   advance;
    logic                   bypass_mode;
    logic [LANES*DATA_W-1:0] lane_in;

`ifdef SKEW_BYPASS_EN
    assign bypass_mode = (state == IDLE) && bypass;
`else
    assign bypass_mode = 1'b0;
`endif

    assign in_ready   = ((state == IDLE) || (state == STREAM)) && !stall;
    assign accept     = in_valid && in_ready;
    assign drain_step = (state == DRAIN);
    assign advance    = (accept || drain_step) && !stall;
    assign lane_in    = accept ? in_data : '0;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Drain pushes LANES-1 zero rows so the last real row reaches the top lane.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            out_enable <= 1'b0;
        end else begin
            out_enable <= advance;
            case (state)
                IDLE: begin
                    if (accept && !bypass_mode) begin
                        if (in_last) begin
                            state     <= LAST_ROW_STATE;
                            drain_cnt <= CNT_W'(LANES - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept && in_last) begin
                        state     <= LAST_ROW_STATE;
                        drain_cnt <= CNT_W'(LANES - 1);
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (drain_cnt == CNT_W'(1)) begin
                            state     <= DONE;
                            drain_cnt <= '0;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            lane_delay #(
                .DEPTH  (i),
                .DATA_W (DATA_W)
            ) u_lane_delay (
                .clk      (clk),
                .n_rst    (n_rst),
                .shift_en (advance),
                .direct   (bypass_mode),
                .d        (lane_in[DATA_W*i +: DATA_W]),
                .q        (out_data[DATA_W*i +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed, scoreboard-based bench for input_skew_buffer; exercises the
// SKEW_BYPASS_EN bypass path only when that macro is defined.
module tb_input_skew_buffer;

    localparam int LANES  = 8;
    localparam int DATA_W = 8;
    localparam int W      = LANES * DATA_W;

    typedef logic [W-1:0] vec_t;

    logic   clk;
    logic   n_rst;
    logic   in_valid;
    logic   in_ready;
    vec_t   in_data;
    logic   in_last;
    logic   stall;
    vec_t   out_data;
    logic   out_enable;
    logic   busy;
    logic   done;
`ifdef SKEW_BYPASS_EN
    logic   bypass;
`endif

    vec_t   rowHist[$];
    vec_t   sb[$];
    vec_t   lastOut;
    logic   pendingEnable;
    int     checkCount;
    int     passCount;

    input_skew_buffer #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
`ifdef SKEW_BYPASS_EN
        .bypass     (bypass),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .stall      (stall),
        .out_data   (out_data),
        .out_enable (out_enable),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane i after an advance shows the row accepted i advances earlier.
    function automatic vec_t expectedSkew();
        vec_t v;
        int   n;
        vec_t r;
        v = '0;
        n = rowHist.size();
        for (int i = 0; i < LANES; i++) begin
            if (n > i) begin
                r = rowHist[n-1-i];
                v[DATA_W*i +: DATA_W] = r[DATA_W*i +: DATA_W];
            end
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic valid, input vec_t data, input logic last,
                                 input logic stallV, input logic direct,
                                 input logic expReady, input logic expAdv);
        in_valid = valid;
        in_data  = data;
        in_last  = last;
        stall    = stallV;
`ifdef SKEW_BYPASS_EN
        bypass   = direct;
`endif
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        @(posedge clk);
        pendingEnable = expAdv;
        if (expAdv) begin
            if (direct) begin
                sb.push_back(data);
            end else begin
                rowHist.push_back((valid && expReady) ? data : '0);
                sb.push_back(expectedSkew());
            end
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input logic expBusy, input logic expDone);
        check("out_enable", {63'd0, out_enable}, {63'd0, pendingEnable});
        if (pendingEnable) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                lastOut = sb.pop_front();
            end
        end
        check("out_data", out_data, lastOut);
        check("busy", {63'd0, busy}, {63'd0, expBusy});
        check("done", {63'd0, done}, {63'd0, expDone});
    endtask

    task automatic step(input logic valid, input vec_t data, input logic last, input logic stallV,
                        input logic expReady, input logic expAdv,
                        input logic expBusy, input logic expDone);
        applyStimulus(valid, data, last, stallV, 1'b0, expReady, expAdv);
        checkOutput(expBusy, expDone);
    endtask

    task automatic drainSteps(input int n, input bit doneAtEnd);
        for (int k = 0; k < n; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, doneAtEnd && (k == n - 1));
        end
    endtask

    task automatic singleRowTile();
        step(1'b1, 64'h0102030405060708, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("lane0_first", {56'd0, out_data[7:0]}, 64'h08);
        drainSteps(LANES - 1, 1'b1);
        check("lane7_last", out_data, 64'h0100000000000000);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checkCount    = 0;
        passCount     = 0;
        lastOut       = '0;
        pendingEnable = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        stall         = 1'b0;
`ifdef SKEW_BYPASS_EN
        bypass        = 1'b0;
`endif
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_data", out_data, '0);
        check("rst_out_enable", {63'd0, out_enable}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        n_rst = 1'b1;

        $display("[TB] single-row tile");
        singleRowTile();

        $display("[TB] stall with last in IDLE is ignored");
        step(1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] four-row tile");
        step(1'b1, 64'h0101010101010101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h0202020202020202, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h0303030303030303, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h0404040404040404, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drainSteps(LANES - 1, 1'b1);
        check("wavefront_lane7", {56'd0, out_data[63:56]}, 64'h04);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] stall mid-stream");
        step(1'b1, 64'h8081828384858687, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h1122334455667788, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 64'hF0E1D2C3B4A59687, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h7F807F807F807F80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drainSteps(LANES - 1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] bubbles in stream and stall in drain");
        step(1'b1, 64'h0A0B0C0D0E0F1011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'hFFFEFDFCFBFAF9F8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drainSteps(3, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drainSteps(LANES - 4, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during drain");
        step(1'b1, 64'h5555555555555555, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drainSteps(3, 1'b0);
        n_rst = 1'b0;
        #1;
        check("midrst_out_data", out_data, '0);
        check("midrst_out_enable", {63'd0, out_enable}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        rowHist.delete();
        sb.delete();
        lastOut       = '0;
        pendingEnable = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        singleRowTile();

`ifdef SKEW_BYPASS_EN
        $display("[TB] bypass row");
        applyStimulus(1'b1, 64'h0202020202020202, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput(1'b0, 1'b0);
        check("bypass_row", out_data, 64'h0202020202020202);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        singleRowTile();
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
